// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Stall-capable data memory: one request at a time, LATENCY wait states, byte-addressed
// little-endian accesses into a doubleword array, sign/zero-extended load responses.
// DEPTH is expected to be a power of two, at least 2.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam logic [3:0]  LatM1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [2:0]  lat_funct3;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;

  logic [63:0] mem [DEPTH];

  logic        acc_go;
  logic        acc_write;
  logic [2:0]  acc_funct3;
  logic [63:0] acc_addr;
  logic [63:0] acc_wdata;
  logic        acc_err;
  logic [63:0] acc_rdata;
  logic [63:0] new_word;

  logic [IdxW-1:0] idx;
  logic [63:0]     rd_word;
  logic [63:0]     shifted;
  logic [63:0]     load_val;
  logic [7:0]      lane_mask;
  logic [63:0]     bit_mask;
  logic            misalign;
  logic            out_of_range;
  logic            illegal;

  // Pick the access source: live bus fields on a zero-latency accept, latched fields otherwise.
  always_comb begin
    if (state == StIdle) begin
      acc_go     = bus.req_valid && (LATENCY == 0);
      acc_write  = bus.req_write;
      acc_funct3 = bus.req_funct3;
      acc_addr   = bus.req_addr;
      acc_wdata  = bus.req_wdata;
    end else begin
      acc_go     = (state == StWait) && (cnt == 4'd0);
      acc_write  = lat_write;
      acc_funct3 = lat_funct3;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
    end
  end

  // Error detection, load extraction and store byte-lane merge for the current access.
  always_comb begin
    case (acc_funct3[1:0])
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = acc_addr[0];
      2'd2:    misalign = |acc_addr[1:0];
      default: misalign = |acc_addr[2:0];
    endcase
    out_of_range = {3'b000, acc_addr[63:3]} >= 64'(DEPTH);
    illegal      = acc_write ? acc_funct3[2] : (acc_funct3 == 3'b111);
    acc_err      = misalign || out_of_range || illegal;

    idx     = acc_addr[IdxW+2:3];
    rd_word = mem[idx];
    shifted = rd_word >> {acc_addr[2:0], 3'b000};

    case (acc_funct3)
      3'b000:  load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_val = shifted;
      3'b100:  load_val = {56'd0, shifted[7:0]};
      3'b101:  load_val = {48'd0, shifted[15:0]};
      3'b110:  load_val = {32'd0, shifted[31:0]};
      default: load_val = 64'd0;
    endcase
    acc_rdata = (acc_write || acc_err) ? 64'd0 : load_val;

    case (acc_funct3[1:0])
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      2'd2:    lane_mask = 8'h0f;
      default: lane_mask = 8'hff;
    endcase
    lane_mask = lane_mask << acc_addr[2:0];
    bit_mask  = 64'd0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    new_word = (rd_word & ~bit_mask) | ((acc_wdata << {acc_addr[2:0], 3'b000}) & bit_mask);
  end

  // Array write on the access edge; reset suppresses a store that has not landed yet.
  always_ff @(posedge clk) begin
    if (acc_go && acc_write && !acc_err && !reset) begin
      mem[idx] <= new_word;
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= 4'd0;
      lat_write    <= 1'b0;
      lat_funct3   <= 3'd0;
      lat_addr     <= 64'd0;
      lat_wdata    <= 64'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.req_valid) begin
            lat_write   <= bus.req_write;
            lat_funct3  <= bus.req_funct3;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state        <= StResp;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= acc_rdata;
              resp_err_q   <= acc_err;
            end else begin
              cnt   <= LatM1;
              state <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt == 4'd0) begin
            state        <= StResp;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= acc_rdata;
            resp_err_q   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            state        <= StIdle;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
